// File: rtl/coproc_cmd_sequencer.sv
// Command sequencer for the vector coprocessor: decodes UART command bytes, streams vector
// payloads into the A/B memories and owns the op code. Optional watchdog: define WDOG_EN.
module coproc_cmd_sequencer #(
    parameter int N_ELEM      = 1024,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              op_finished,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        op,
    output logic              busy,
    output logic              load_done,
    output logic              cmd_done,
    output logic              cmd_err
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

    localparam logic [7:0] CMD_WR_A  = 8'd1;
    localparam logic [7:0] CMD_WR_B  = 8'd2;
    localparam logic [7:0] CMD_RD_A  = 8'd99;
    localparam logic [7:0] CMD_RD_B  = 8'd100;
    localparam logic [7:0] CMD_SUM   = 8'd101;
    localparam logic [7:0] CMD_AVG   = 8'd102;
    localparam logic [7:0] CMD_MAN   = 8'd103;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);

    state_t            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              busy_q, busy_d;
    logic              load_done_q, load_done_d;
    logic              cmd_done_q, cmd_done_d;
    logic              cmd_err_q, cmd_err_d;

`ifdef WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_expired;
    assign wdog_expired = (wdog_q == WDOG_LAST);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wr_en_d     = 1'b0;
        wr_sel_d    = wr_sel_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        count_d     = count_q;
        load_done_d = 1'b0;
        cmd_done_d  = 1'b0;
        cmd_err_d   = 1'b0;
`ifdef WDOG_EN
        wdog_d      = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_ready) begin
                    case (rx_data)
                        CMD_WR_A, CMD_WR_B: begin
                            state_d  = LOAD;
                            wr_sel_d = (rx_data == CMD_WR_B);
                            count_d  = '0;
`ifdef WDOG_EN
                            wdog_d   = '0;
`endif
                        end
                        CMD_RD_A, CMD_RD_B, CMD_SUM, CMD_AVG, CMD_MAN: begin
                            state_d = EXEC;
                            op_d    = rx_data;
`ifdef WDOG_EN
                            wdog_d  = '0;
`endif
                        end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            LOAD: begin
                if (rx_ready) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = rx_data;
                    wr_addr_d = count_q;
`ifdef WDOG_EN
                    wdog_d    = '0;
`endif
                    // Last element: the count parks at the final address instead of wrapping.
                    if (count_q == LAST_ADDR) begin
                        load_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
`ifdef WDOG_EN
                else if (wdog_expired) begin
                    cmd_err_d = 1'b1;
                    op_d      = 8'd0;
                    state_d   = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            EXEC: begin
                if (rx_ready) begin
                    cmd_err_d = 1'b1;
                end
                if (op_finished) begin
                    op_d       = 8'd0;
                    cmd_done_d = 1'b1;
                    state_d    = DONE;
                end
`ifdef WDOG_EN
                else if (wdog_expired) begin
                    cmd_err_d = 1'b1;
                    op_d      = 8'd0;
                    state_d   = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                if (rx_ready) begin
                    cmd_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'd0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
`ifdef WDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wr_en_q     <= wr_en_d;
            wr_sel_q    <= wr_sel_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            cmd_done_q  <= cmd_done_d;
            cmd_err_q   <= cmd_err_d;
`ifdef WDOG_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_sel    = wr_sel_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign op        = op_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign cmd_done  = cmd_done_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_coproc_cmd_sequencer.sv
// Directed bench for coproc_cmd_sequencer (N_ELEM=4, TIMEOUT_CYC=50); expected values are hand-computed.
module tb_coproc_cmd_sequencer;

    localparam int N_ELEM      = 4;
    localparam int ADDR_W      = 2;
    localparam int TIMEOUT_CYC = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready = 1'b0;
    logic              op_finished = 1'b0;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        op;
    logic              busy;
    logic              load_done;
    logic              cmd_done;
    logic              cmd_err;

    int vectors = 0;
    int miscompares = 0;

    coproc_cmd_sequencer #(
        .N_ELEM(N_ELEM),
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .op_finished(op_finished),
        .wr_en(wr_en),
        .wr_sel(wr_sel),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .op(op),
        .busy(busy),
        .load_done(load_done),
        .cmd_done(cmd_done),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic pulseFinished();
        op_finished = 1'b1;
        tick();
        op_finished = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed hang expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [7:0] b;
        int         hold_bad;
        int         err_at;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_op", op, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_wr_sel", wr_sel, 0);
        checkOutput("rst_strobes", {load_done, cmd_done, cmd_err}, 0);
        rst = 1'b0;
        tick();

        // Load vector A
        applyStimulus(8'h01);
        checkOutput("loadA_busy", busy, 1);
        checkOutput("loadA_no_wr", wr_en, 0);
        for (int i = 0; i < N_ELEM; i++) begin
            b = 8'h0A + 8'(i);
            applyStimulus(b);
            checkOutput("loadA_wr_en", wr_en, 1);
            checkOutput("loadA_wr_sel", wr_sel, 0);
            checkOutput("loadA_wr_addr", wr_addr, 32'(i));
            checkOutput("loadA_wr_data", wr_data, 32'(b));
            checkOutput("loadA_load_done", load_done, (i == N_ELEM - 1) ? 1 : 0);
        end
        checkOutput("loadA_busy_after", busy, 0);
        tick();
        checkOutput("loadA_wr_en_off", wr_en, 0);
        checkOutput("loadA_done_off", load_done, 0);

        // Exec sumVec
        applyStimulus(8'h65);
        checkOutput("exec_op", op, 101);
        checkOutput("exec_busy", busy, 1);
        repeat (20) tick();
        checkOutput("exec_op_held", op, 101);
        checkOutput("exec_no_done", cmd_done, 0);
        pulseFinished();
        checkOutput("exec_cmd_done", cmd_done, 1);
        checkOutput("exec_op_cleared", op, 0);
        tick();
        checkOutput("exec_done_off", cmd_done, 0);
        checkOutput("exec_busy_off", busy, 0);

        // Illegal command in IDLE
        applyStimulus(8'h07);
        checkOutput("illegal_err", cmd_err, 1);
        checkOutput("illegal_op", op, 0);
        checkOutput("illegal_busy", busy, 0);
        tick();
        checkOutput("illegal_err_off", cmd_err, 0);

        // Overrun during EXEC
        applyStimulus(8'h67);
        checkOutput("ovr_op", op, 103);
        applyStimulus(8'h01);
        checkOutput("ovr_err", cmd_err, 1);
        checkOutput("ovr_op_held", op, 103);
        checkOutput("ovr_no_wr", wr_en, 0);
        checkOutput("ovr_busy", busy, 1);
        tick();
        checkOutput("ovr_err_off", cmd_err, 0);
        pulseFinished();
        checkOutput("ovr_cmd_done", cmd_done, 1);
        // Byte arriving in the DONE cycle is dropped
        applyStimulus(8'h01);
        checkOutput("done_drop_err", cmd_err, 1);
        checkOutput("done_drop_busy", busy, 0);
        checkOutput("done_drop_wr", wr_en, 0);

        // op_finished while idle does nothing
        pulseFinished();
        checkOutput("idle_fin_done", cmd_done, 0);
        checkOutput("idle_fin_busy", busy, 0);

        // Reset mid-load
        applyStimulus(8'h02);
        applyStimulus(8'h11);
        checkOutput("rml_wr_sel", wr_sel, 1);
        checkOutput("rml_addr0", wr_addr, 0);
        applyStimulus(8'h22);
        checkOutput("rml_addr1", wr_addr, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rml_busy", busy, 0);
        checkOutput("rml_wr_addr", wr_addr, 0);
        checkOutput("rml_wr_sel", wr_sel, 0);
        checkOutput("rml_strobes", {wr_en, load_done, cmd_done, cmd_err}, 0);
        applyStimulus(8'h02);
        applyStimulus(8'h33);
        checkOutput("rml_restart_addr", wr_addr, 0);
        checkOutput("rml_restart_data", wr_data, 8'h33);
        checkOutput("rml_restart_sel", wr_sel, 1);
        for (int i = 1; i < N_ELEM; i++) begin
            applyStimulus(8'h40 + 8'(i));
            checkOutput("rml_fill_addr", wr_addr, 32'(i));
        end
        checkOutput("rml_load_done", load_done, 1);
        checkOutput("rml_busy_after", busy, 0);
        tick();

        // readVec_A without op_finished
        applyStimulus(8'h63);
        checkOutput("wd_op", op, 99);
`ifdef WDOG_EN
        err_at = -1;
        for (int c = 1; c <= 60 && err_at < 0; c++) begin
            tick();
            if (cmd_err) err_at = c;
        end
        checkOutput("wd_err_cycle", err_at, TIMEOUT_CYC);
        checkOutput("wd_op_cleared", op, 0);
        checkOutput("wd_busy", busy, 0);
`else
        err_at   = 0;
        hold_bad = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (op !== 8'd99 || busy !== 1'b1) hold_bad++;
            if (cmd_err === 1'b1) err_at++;
        end
        checkOutput("nowd_hold_breaks", hold_bad, 0);
        checkOutput("nowd_no_err", err_at, 0);
        checkOutput("nowd_op", op, 99);
        pulseFinished();
        checkOutput("nowd_cmd_done", cmd_done, 1);
        checkOutput("nowd_op_cleared", op, 0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
